// File: rtl/mac_operand_feeder.sv
// -----------------------------------------------------------------------------
// mac_operand_feeder
//
// Loads one tile of operands for the 16x16 MAC array from a serial word
// stream, fires the array enable for a single cycle, then waits for the
// registered array result and pulses done_o.
//
// Sequence: IDLE -> LOAD_W -> LOAD_B -> LOAD_A -> FIRE -> WAIT -> IDLE.
// LOAD_W is skipped when a tile starts with reuse_w_i=1 and a complete
// weight set has been loaded since the last reset.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start_i           begin a tile (only looked at in IDLE)
//   reuse_w_i         sampled with start_i: keep the held weights
//   in_valid_i        stream word valid
//   in_data_i         stream word
//   in_ready_o        a word is accepted this cycle (LOAD states only)
//   weight_o          weight vector, word j at [j*DATA_WIDTH +: DATA_WIDTH]
//   data_b_o          data_b vector, same packing
//   data_a_o          data_a vector, same packing
//   mac_enable_o      one-cycle array enable
//   busy_o            high whenever not IDLE
//   done_o            one-cycle pulse, array result valid this cycle
//
// Optional build macro MAC_FEEDER_PERF_EN adds:
//   perf_tiles_o      completed tiles, wraps at 16 bits
//   perf_stall_o      LOAD cycles with in_valid_i low, saturates at 0xFFFF
// -----------------------------------------------------------------------------
module mac_operand_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_ROWS = 16,
    parameter int ARRAY_COLS = 16,
    parameter int RESULT_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic                             reuse_w_i,
    input  logic                             in_valid_i,
    input  logic [DATA_WIDTH-1:0]            in_data_i,
    output logic                             in_ready_o,
    output logic [ARRAY_COLS*DATA_WIDTH-1:0] weight_o,
    output logic [ARRAY_ROWS*DATA_WIDTH-1:0] data_b_o,
    output logic [ARRAY_COLS*DATA_WIDTH-1:0] data_a_o,
    output logic                             mac_enable_o,
    output logic                             busy_o,
    output logic                             done_o
`ifdef MAC_FEEDER_PERF_EN
    ,
    output logic [15:0]                      perf_tiles_o,
    output logic [15:0]                      perf_stall_o
`endif
);

    localparam int MAX_DIM = (ARRAY_ROWS > ARRAY_COLS) ? ARRAY_ROWS : ARRAY_COLS;
    localparam int CNT_W   = $clog2(MAX_DIM) + 1;
    localparam int WAIT_W  = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

    localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(ARRAY_COLS - 1);
    localparam logic [CNT_W-1:0]  LAST_ROW  = CNT_W'(ARRAY_ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RESULT_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_LOAD_A,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t                          state_q,   state_d;
    logic [CNT_W-1:0]                cnt_q,     cnt_d;
    logic [WAIT_W-1:0]               wait_q,    wait_d;
    logic                            w_valid_q, w_valid_d;
    logic [ARRAY_COLS*DATA_WIDTH-1:0] weight_q, weight_d;
    logic [ARRAY_ROWS*DATA_WIDTH-1:0] data_b_q, data_b_d;
    logic [ARRAY_COLS*DATA_WIDTH-1:0] data_a_q, data_a_d;

    // Handshake and status are pure decodes of the registered state, so
    // in_ready_o never depends on in_valid_i.
    assign in_ready_o   = (state_q == S_LOAD_W) || (state_q == S_LOAD_B) ||
                          (state_q == S_LOAD_A);
    assign mac_enable_o = (state_q == S_FIRE);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_WAIT) && (wait_q == '0);

    assign weight_o = weight_q;
    assign data_b_o = data_b_q;
    assign data_a_o = data_a_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        w_valid_d = w_valid_q;
        weight_d  = weight_q;
        data_b_d  = data_b_q;
        data_a_d  = data_a_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d   = '0;
                    state_d = (reuse_w_i && w_valid_q) ? S_LOAD_B : S_LOAD_W;
                end
            end
            // In the LOAD states in_ready_o is high, so in_valid_i alone marks a
            // beat; with in_valid_i low the counter and state simply hold.
            S_LOAD_W: begin
                if (in_valid_i) begin
                    for (int j = 0; j < ARRAY_COLS; j++)
                        if (cnt_q == CNT_W'(j))
                            weight_d[j*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                    if (cnt_q == LAST_COL) begin
                        cnt_d     = '0;
                        w_valid_d = 1'b1;
                        state_d   = S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_valid_i) begin
                    for (int j = 0; j < ARRAY_ROWS; j++)
                        if (cnt_q == CNT_W'(j))
                            data_b_d[j*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                    if (cnt_q == LAST_ROW) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (in_valid_i) begin
                    for (int j = 0; j < ARRAY_COLS; j++)
                        if (cnt_q == CNT_W'(j))
                            data_a_d[j*DATA_WIDTH +: DATA_WIDTH] = in_data_i;
                    if (cnt_q == LAST_COL) begin
                        cnt_d   = '0;
                        state_d = S_FIRE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIRE: begin
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_IDLE;
                else              wait_d  = wait_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            w_valid_q <= 1'b0;
            weight_q  <= '0;
            data_b_q  <= '0;
            data_a_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            w_valid_q <= w_valid_d;
            weight_q  <= weight_d;
            data_b_q  <= data_b_d;
            data_a_q  <= data_a_d;
        end
    end

`ifdef MAC_FEEDER_PERF_EN
    logic [15:0] tiles_q, tiles_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        tiles_d = tiles_q;
        stall_d = stall_q;
        if (done_o)
            tiles_d = tiles_q + 16'd1;
        if (in_ready_o && !in_valid_i && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_q <= '0;
            stall_q <= '0;
        end else begin
            tiles_q <= tiles_d;
            stall_q <= stall_d;
        end
    end

    assign perf_tiles_o = tiles_q;
    assign perf_stall_o = stall_q;
`endif

endmodule
